// File: rtl/axis32to8.sv
// 32-bit to 8-bit AXI-Stream width converter: each accepted word is emitted as its
// kept byte lanes, one per cycle, in the lane order chosen by BIG_ENDIAN.
module axis32to8 #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic [31:0] m_data,
    input  logic [3:0]  m_keep,
    input  logic        m_last,
    input  logic        m_valid,
    output logic        m_ready,
    output logic [7:0]  s_data,
    output logic        s_last,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        drop_err
);

    typedef enum logic {EMPTY, DRAIN} state_t;

    state_t      state;
    logic [31:0] hold;
    logic [3:0]  pend;
    logic        hlast;

    logic [31:0] hold_n;
    logic [3:0]  pend_n;
    logic        hlast_n;
    logic [1:0]  lane_n;
    logic        in_xfer;
    logic        out_xfer;

    // Lane to emit next: lowest pending lane, or highest when BIG_ENDIAN.
    function automatic logic [1:0] pick(input logic [3:0] p);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (BIG_ENDIAN) begin
                if (p[i]) idx = 2'(i);
            end else begin
                if (p[3 - i]) idx = 2'(3 - i);
            end
        end
        return idx;
    endfunction

    assign m_ready = rstf && ((state == EMPTY) || ($onehot(pend) && s_ready));

    always_comb begin
        in_xfer  = m_valid && m_ready;
        out_xfer = s_valid && s_ready;
        hold_n   = hold;
        pend_n   = pend;
        hlast_n  = hlast;
        if (out_xfer) pend_n = pend & ~(4'b0001 << pick(pend));
        // A load overrides the final-byte clear so back-to-back words have no bubble.
        if (in_xfer) begin
            hold_n  = m_data;
            pend_n  = m_keep;
            hlast_n = m_last;
        end
        lane_n = pick(pend_n);
    end

    // Outputs are registered from next-state values, so they line up with state.
    always_ff @(posedge clk) begin
        if (!rstf) begin
            state    <= EMPTY;
            hold     <= '0;
            pend     <= '0;
            hlast    <= 1'b0;
            s_data   <= '0;
            s_valid  <= 1'b0;
            s_last   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            hold     <= hold_n;
            pend     <= pend_n;
            hlast    <= hlast_n;
            state    <= (pend_n != '0) ? DRAIN : EMPTY;
            s_valid  <= (pend_n != '0);
            s_data   <= hold_n[{lane_n, 3'b000} +: 8];
            s_last   <= hlast_n && $onehot(pend_n);
            drop_err <= in_xfer && (m_keep == '0) && m_last;
        end
    end

endmodule

// File: tb/tb_axis32to8.sv
// Scoreboard bench for axis32to8: little- and big-endian instances share stimulus
// and are checked against a byte-queue reference model.
module tb_axis32to8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstf, m_last, m_valid, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_ready0, m_ready1, s_last0, s_last1, s_valid0, s_valid1, drop0, drop1;
    logic [7:0]  s_data0, s_data1;

    axis32to8 #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rstf(rstf), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready0), .s_data(s_data0), .s_last(s_last0),
        .s_valid(s_valid0), .s_ready(s_ready), .drop_err(drop0)
    );

    axis32to8 #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rstf(rstf), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready1), .s_data(s_data1), .s_last(s_last1),
        .s_valid(s_valid1), .s_ready(s_ready), .drop_err(drop1)
    );

    typedef struct {
        logic [7:0] le;
        logic [7:0] be;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] le_q[$];
    logic [7:0] be_q[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    int         mode = 0;
    int         ph = 0;
    int         sz;
    logic       exp_rdy, exp_drop = 1'b0, hold_prev = 1'b0, rst_seen = 1'b0;
    logic [7:0] prev_le, prev_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // s_ready pattern: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
    initial begin
        s_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: s_ready = 1'b1;
                1: s_ready = 1'($urandom_range(0, 1));
                default: begin
                    s_ready = (ph % 3 == 0);
                    ph++;
                end
            endcase
        end
    end

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        sz = exp_q.size();
        if (!rstf) begin
            exp_q.delete();
            exp_drop  = 1'b0;
            hold_prev = 1'b0;
            chk("m_ready_in_reset", {m_ready0, m_ready1}, 0);
            if (rst_seen) begin
                chk("s_valid_reset", {s_valid0, s_valid1}, 0);
                chk("s_data_reset", {s_data0, s_data1}, 0);
                chk("s_last_drop_reset", {s_last0, s_last1, drop0, drop1}, 0);
            end
            rst_seen = 1'b1;
        end else begin
            exp_rdy = (sz == 0) || (sz == 1 && s_ready);
            chk("m_ready", {m_ready0, m_ready1}, {2{exp_rdy}});
            chk("s_valid", {s_valid0, s_valid1}, {2{sz != 0}});
            chk("drop_err", {drop0, drop1}, {2{exp_drop}});
            if (hold_prev) chk("s_data_stall", {s_data0, s_data1}, {prev_le, prev_be});
            if (sz != 0 && s_valid0) begin
                chk("s_data", {s_data0, s_data1}, {exp_q[0].le, exp_q[0].be});
                chk("s_last", {s_last0, s_last1}, {2{exp_q[0].last}});
                if (s_ready) void'(exp_q.pop_front());
            end
            hold_prev = s_valid0 && !s_ready;
            prev_le   = s_data0;
            prev_be   = s_data1;
            exp_drop  = 1'b0;
            if (m_valid && m_ready0) begin
                exp_drop = (m_keep == 4'h0) && m_last;
                for (int i = 0; i < 4; i++)
                    if (m_keep[i]) le_q.push_back(m_data[8*i +: 8]);
                for (int i = 3; i >= 0; i--)
                    if (m_keep[i]) be_q.push_back(m_data[8*i +: 8]);
                for (int k = 0; k < le_q.size(); k++) begin
                    e.le   = le_q[k];
                    e.be   = be_q[k];
                    e.last = m_last && (k == le_q.size() - 1);
                    exp_q.push_back(e);
                end
                le_q.delete();
                be_q.delete();
            end
            rst_seen = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        m_data  = d;
        m_keep  = k;
        m_last  = l;
        m_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (m_ready0) break;
            t++;
            if (t > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no m_ready, expected within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            m_valid = 1'b0;
            m_data  = $urandom;
            m_keep  = 4'($urandom);
            m_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstf    = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        m_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstf = 1'b1;
        idle(2);

        mode = 0;
        send_word(32'hDDCCBBAA, 4'hF, 1'b1);
        idle(5);

        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b1);
        idle(10);

        send_word(32'h44332211, 4'b1010, 1'b1);
        idle(4);

        mode = 2;
        send_word(32'h88776655, 4'hF, 1'b1);
        idle(15);

        mode = 0;
        idle(2);
        send_word(32'hDEADBEEF, 4'h0, 1'b1);
        idle(3);

        send_word(32'hA1B2C3D4, 4'hF, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstf = 1'b1;
        idle(3);

        for (int w = 0; w < 400; w++) begin
            mode = $urandom_range(0, 2);
            send_word($urandom, 4'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end

        mode = 0;
        idle(30);
        chk("drain_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis32to8.md
AXIS32TO8 -- requirements
Module: axis32to8

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 0, where 0 emits byte lane 0 (bits 7:0) first and 1 emits byte lane 3 (bits 31:24) first.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-003 Port rstf SHALL be an input, 1 bit wide, and is the reset: synchronous, active-low.
REQ-004 Port m_data SHALL be an input, 32 bits wide, carrying the input word.
REQ-005 Port m_keep SHALL be an input, 4 bits wide; bit i qualifies byte lane i, m_data[8i+7:8i].
REQ-006 Port m_last SHALL be an input, 1 bit wide, and marks the final word of a packet.
REQ-007 Port m_valid SHALL be an input, 1 bit wide, and is the input-word valid.
REQ-008 Port m_ready SHALL be an output, 1 bit wide, and is the input-word ready.
REQ-009 Port s_data SHALL be an output, 8 bits wide, carrying the output byte.
REQ-010 Port s_last SHALL be an output, 1 bit wide, and marks the final byte of a packet.
REQ-011 Port s_valid SHALL be an output, 1 bit wide, and is the output-byte valid.
REQ-012 Port s_ready SHALL be an input, 1 bit wide, and is the output-byte ready.
REQ-013 Port drop_err SHALL be an output, 1 bit wide: a one-cycle pulse when a word with m_keep==0 and m_last==1 is discarded.

Function
REQ-014 An input transfer SHALL occur on any cycle with m_valid & m_ready; an output transfer SHALL occur on any cycle with s_valid & s_ready.
REQ-015 Internal state SHALL consist of:
- a 32-bit holding register;
- a 4-bit pending mask, the kept lanes not yet emitted;
- a held-last flag;
- state EMPTY (pending mask == 0) or DRAIN (pending mask != 0).
REQ-016 On an input transfer, the block SHALL load m_data and m_last into the holding register and held-last flag, and load m_keep into the pending mask.
REQ-017 s_data, s_valid and s_last SHALL be driven from registers only, with no combinational path from m_* to s_*.
REQ-018 s_valid SHALL be 1 exactly in DRAIN.
REQ-019 s_data SHALL be the lane of the lowest set pending bit when BIG_ENDIAN=0, or of the highest set pending bit when BIG_ENDIAN=1.
REQ-020 Lanes whose keep bit is 0 SHALL never be emitted.
REQ-021 On an output transfer, the block SHALL clear the emitted lane's pending bit.
REQ-022 s_last SHALL be 1 only when the held-last flag is 1 and exactly one pending bit remains.
REQ-023 m_ready SHALL be a combinational function of the current state and s_ready:
- 1 in EMPTY;
- in DRAIN, 1 only when exactly one pending bit remains and s_ready==1;
- 0 otherwise.
REQ-024 When an output transfer of the final pending byte coincides with an input transfer, the new word SHALL be loaded in that same cycle with no bubble cycle, so that sustained throughput with s_ready held at 1 is one byte per cycle.
REQ-025 Latency SHALL be: a word accepted in cycle N presents its first byte with s_valid=1 in cycle N+1.
REQ-026 In DRAIN with s_ready=0, s_data, s_last, s_valid and the pending mask SHALL hold unchanged.
REQ-027 A word with m_keep==0 SHALL be accepted in one cycle and discarded, the block remaining in EMPTY.
REQ-028 If that discarded word had m_last=1, drop_err SHALL pulse high for exactly the following cycle, and no s_last is produced for it.
REQ-029 A non-contiguous keep pattern (e.g. 4'b1010) SHALL emit only the kept lanes, in lane order, with no gap cycles between them.
REQ-030 The block SHALL ignore m_data, m_keep and m_last when m_valid=0, and they do not affect state.

Reset
REQ-031 While rstf==0 at a rising edge of clk, the block SHALL clear the state to EMPTY and clear the pending mask, held-last flag and holding register to 0.
REQ-032 The reset value of every output SHALL be: s_valid=0, s_data=8'h00, s_last=0, drop_err=0.
REQ-033 m_ready SHALL be forced to 0 while rstf==0, and be 1 on the first cycle after release.
REQ-034 A reset asserted mid-word SHALL discard the remaining pending bytes, with no s_valid in the cycle after reset is sampled.

Verification
REQ-035 Scenario 1: BIG_ENDIAN=0, m_data=32'hDDCCBBAA, m_keep=4'hF, m_last=1, s_ready held 1 -> s_data AA, BB, CC, DD on four consecutive cycles, with s_last=1 on DD only.
REQ-036 Scenario 2: back-to-back words 32'h03020100 and 32'h07060504, keep=4'hF, s_ready=1 -> bytes 00..07 on eight consecutive cycles; m_ready=1 in the cycle byte 03 transfers.
REQ-037 Scenario 3: m_data=32'h44332211, m_keep=4'b1010, m_last=1, BIG_ENDIAN=1 -> 44 then 22, with s_last=1 on 22.
REQ-038 Scenario 4: s_ready toggling 1,0,0,1,... during a word -> no byte lost or duplicated; s_data stable while s_ready=0; m_ready=0 until the final byte transfers.
REQ-039 Scenario 5: m_keep=4'h0, m_last=1 -> accepted in one cycle, no s_valid, drop_err=1 for one cycle.
REQ-040 Scenario 6: rstf driven 0 after 2 of 4 bytes are emitted -> s_valid=0 and m_ready=0 during reset; m_ready=1 and no leftover bytes after release.
